cpu_sequencer: RTL

Multi-cycle control FSM for the 16-bit CPU. Sequences fetch, decode, execute, memory and writeback around the combinational opcode decoder. Arbitrates the single shared memory port between instruction fetch and data access, using a req/ready handshake. Gates the decoder's write enables so that register file, NZ flags, PC and memory update only in their proper cycle.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_sequencer_if.sv | 31 +++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/cpu_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path.
// Used by the sequencer, its memory interface and the opcode decoder.
package cpu_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned WBSRC_W = 3;
   localparam int unsigned PCSRC_W = 2;

   // Sequencer state encoding; 6 is unused and treated as illegal.
   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      FAULT  = 3'd7
   } seq_state_t;

   // Writeback source select produced by the opcode decoder.
   typedef enum logic [WBSRC_W-1:0] {
      WBSRC_MEM = 3'b000,
      WBSRC_ALU = 3'b001,
      WBSRC_PC  = 3'b010,
      WBSRC_IMM = 3'b011,
      WBSRC_SHF = 3'b100
   } wbsrc_t;

   // Next-PC source select produced by the opcode decoder.
   typedef enum logic [PCSRC_W-1:0] {
      PCSRC_INC = 2'b00,
      PCSRC_BR  = 2'b01,
      PCSRC_JMP = 2'b10,
      PCSRC_REG = 2'b11
   } pcsrc_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Shared memory port handshake between the sequencer and memory.
//   mem_req   : request strobe, held until mem_ready
//   mem_sel   : 0 = instruction fetch, 1 = data access
//   mem_we    : data write enable, qualified by mem_req
//   mem_ready : memory completes the current request this cycle
//   mem_err   : error status, valid only with mem_ready
interface cpu_sequencer_if;

   logic mem_req;
   logic mem_sel;
   logic mem_we;
   logic mem_ready;
   logic mem_err;

   modport master (
      output mem_req,
      output mem_sel,
      output mem_we,
      input  mem_ready,
      input  mem_err
   );

   modport slave (
      input  mem_req,
      input  mem_sel,
      input  mem_we,
      output mem_ready,
      output mem_err
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited for ready.
//   clk, reset : clock and asynchronous active-low reset
//   clr        : force the count to zero (has priority over en)
//   en         : advance the count by one
//   expired    : count has reached MEM_TIMEOUT
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;

   // Saturates at MEM_TIMEOUT so expired cannot wrap back to zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en && !expired) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign expired = (r_cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB, arbitrates the single memory port
// between fetch and data access, and gates decoder write enables to
// their proper cycle.
//   clk, reset        : clock and asynchronous active-low reset
//   run               : permission to start a new fetch (IDLE/WB only)
//   dec_*             : control fields from the opcode decoder
//   mem               : shared memory handshake (master side)
//   ir_load, mdr_load : capture fetched instruction / load data
//   pc_load, reg_we,
//   nz_we             : gated architectural updates (WB only)
//   fault             : sticky fault indicator
//   state_o           : current state encoding
//   retired           : completed-instruction count
// Outputs are combinational decodes of the state register and decoder
// inputs, so a strobe asserts in the same cycle its condition is seen.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned RETIRE_W    = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 dec_regwrite,
   input  logic                 dec_memwrite,
   input  logic                 dec_nz,
   input  logic [WBSRC_W-1:0]   dec_wbsrc,
   cpu_sequencer_if.master      mem,
   output logic                 ir_load,
   output logic                 mdr_load,
   output logic                 pc_load,
   output logic                 reg_we,
   output logic                 nz_we,
   output logic                 fault,
   output logic [STATE_W-1:0]   state_o,
   output logic [RETIRE_W-1:0]  retired
);

   seq_state_t            r_state;
   seq_state_t            w_state_nxt;
   logic [RETIRE_W-1:0]   r_retired;

   logic w_mem_req;
   logic w_mem_sel;
   logic w_mem_we;
   logic w_ir_load;
   logic w_mdr_load;
   logic w_pc_load;
   logic w_reg_we;
   logic w_nz_we;
   logic w_fault;
   logic w_tmr_clr;
   logic w_tmr_en;
   logic w_tmr_expired;
   logic w_is_load;

   assign w_is_load = (dec_wbsrc == WBSRC_MEM) && !dec_memwrite;

   // Wait counter is held clear outside memory states, so it starts at
   // zero on every entry to FETCH or MEM.
   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (w_tmr_clr),
      .en      (w_tmr_en),
      .expired (w_tmr_expired)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_mem_req   = 1'b0;
      w_mem_sel   = 1'b0;
      w_mem_we    = 1'b0;
      w_ir_load   = 1'b0;
      w_mdr_load  = 1'b0;
      w_pc_load   = 1'b0;
      w_reg_we    = 1'b0;
      w_nz_we     = 1'b0;
      w_fault     = 1'b0;
      w_tmr_clr   = 1'b1;
      w_tmr_en    = 1'b0;

      case (r_state)
         IDLE: begin
            if (run) begin
               w_state_nxt = FETCH;
            end
         end

         FETCH: begin
            w_mem_req = 1'b1;
            w_tmr_clr = 1'b0;
            // Ready on the expiry cycle still completes the fetch.
            if (mem.mem_ready) begin
               if (mem.mem_err) begin
                  w_state_nxt = FAULT;
               end else begin
                  w_ir_load   = 1'b1;
                  w_state_nxt = DECODE;
               end
            end else if (w_tmr_expired) begin
               w_state_nxt = FAULT;
            end else begin
               w_tmr_en = 1'b1;
            end
         end

         DECODE: begin
            w_state_nxt = EXEC;
         end

         EXEC: begin
            if ((dec_wbsrc == WBSRC_MEM) || dec_memwrite) begin
               w_state_nxt = MEM;
            end else begin
               w_state_nxt = WB;
            end
         end

         MEM: begin
            w_mem_req = 1'b1;
            w_mem_sel = 1'b1;
            w_mem_we  = dec_memwrite;
            w_tmr_clr = 1'b0;
            if (mem.mem_ready) begin
               if (mem.mem_err) begin
                  w_state_nxt = FAULT;
               end else begin
                  w_mdr_load  = w_is_load;
                  w_state_nxt = WB;
               end
            end else if (w_tmr_expired) begin
               w_state_nxt = FAULT;
            end else begin
               w_tmr_en = 1'b1;
            end
         end

         WB: begin
            w_reg_we    = dec_regwrite;
            w_nz_we     = dec_nz;
            w_pc_load   = 1'b1;
            w_state_nxt = run ? FETCH : IDLE;
         end

         FAULT: begin
            w_fault = 1'b1;
         end

         default: begin
            w_state_nxt = FAULT;
         end
      endcase
   end

   // Retired-instruction counter; wraps naturally at 2^RETIRE_W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retired <= '0;
      end else if (r_state == WB) begin
         r_retired <= r_retired + RETIRE_W'(1);
      end
   end

   assign mem.mem_req = w_mem_req;
   assign mem.mem_sel = w_mem_sel;
   assign mem.mem_we  = w_mem_we;
   assign ir_load     = w_ir_load;
   assign mdr_load    = w_mdr_load;
   assign pc_load     = w_pc_load;
   assign reg_we      = w_reg_we;
   assign nz_we       = w_nz_we;
   assign fault       = w_fault;
   assign state_o     = r_state;
   assign retired     = r_retired;

endmodule
